memory_initiator: RTL and testbench

MEMORY_INITIATOR -- requirements
Module: memory_initiator

---
 rtl/memory_pkg.sv | 16 +
 rtl/mem_timeout_counter.sv | 31 +++
 rtl/memory_initiator.sv | 125 ++++++++++++
 tb/tb_memory_initiator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and defaults for the memory initiator.
// FSM state encoding and datapath/timeout defaults.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int TIMEOUT_DEF    = 255;
    localparam int WAIT_W         = 8;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request.
// hit_o flags that this enabled cycle brings the count to the limit.
module mem_timeout_counter
    import memory_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [WAIT_W-1:0] limit_i,
    output logic              hit_o
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + WAIT_W'(1);
    assign hit_o = enable_i && (cnt_d == limit_i);

    // Count waiting cycles; cleared when a new request is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_initiator.sv
// Single-outstanding memory initiator with response buffering,
// burst counting and a sticky timeout error state.
module memory_initiator
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_q,
    input  logic                  mem_done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            count,
    output logic                  burst_done,
    output logic                  error
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [4:0]        BLEN  = 5'(BURST_LEN);

    state_t                state_q;
    logic                  in_ready_q;
    logic                  mem_enable_q;
    logic                  out_valid_q;
    logic                  burst_done_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] mem_a_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [3:0]            count_q;
    logic [4:0]            count_d;
    logic                  accept;
    logic                  wait_en;
    logic                  wait_hit;

    assign accept  = (state_q == IDLE) && in_ready_q && in_valid;
    assign wait_en = (state_q == REQ) && !mem_done;
    assign count_d = {1'b0, count_q} + 5'd1;

    mem_timeout_counter u_wait (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (accept),
        .enable_i (wait_en),
        .limit_i  (LIMIT),
        .hit_o    (wait_hit)
    );

    // Transaction FSM with all handshake and status outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            mem_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
            burst_done_q <= 1'b0;
            error_q      <= 1'b0;
            mem_a_q      <= '0;
            out_data_q   <= '0;
            count_q      <= '0;
        end else begin
            burst_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        mem_a_q      <= in_data;
                        in_ready_q   <= 1'b0;
                        mem_enable_q <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_done) begin
                        out_data_q   <= mem_q;
                        out_valid_q  <= 1'b1;
                        mem_enable_q <= 1'b0;
                        state_q      <= RESP;
                    end else if (wait_hit) begin
                        mem_enable_q <= 1'b0;
                        error_q      <= 1'b1;
                        state_q      <= ERR;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                        if (count_d == BLEN) begin
                            count_q      <= '0;
                            burst_done_q <= 1'b1;
                        end else begin
                            count_q <= count_d[3:0];
                        end
                    end
                end
                ERR: begin
                    in_ready_q   <= 1'b0;
                    out_valid_q  <= 1'b0;
                    mem_enable_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_a      = mem_a_q;
    assign mem_enable = mem_enable_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign burst_done = burst_done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_memory_initiator.sv
// Directed and randomized checks of memory_initiator against a
// transaction-level model of latency, burst count and timeout.
module tb_memory_initiator;

    localparam int DW = 16;
    localparam int BL = 8;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] mem_a;
    logic          mem_enable;
    logic [DW-1:0] mem_q = '0;
    logic          mem_done = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    count;
    logic          burst_done;
    logic          error;

    int compared   = 0;
    int mismatched = 0;
    int exp_count  = 0;
    int bursts     = 0;

    always #5 clock = ~clock;

    memory_initiator #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_a      (mem_a),
        .mem_enable (mem_enable),
        .mem_q      (mem_q),
        .mem_done   (mem_done),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .burst_done (burst_done),
        .error      (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One transaction: accept, wait lat REQ cycles for mem_done (lat > TO
    // means it never comes), then bp cycles of backpressure before handshake.
    task automatic txn(input logic [DW-1:0] d, input int lat,
                       input logic [DW-1:0] q, input int bp);
        int n;
        bit ok;
        chk("ready_before", 32'(in_ready), 1);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        chk("enable_on", 32'(mem_enable), 1);
        chk("ready_off", 32'(in_ready), 0);
        chk("mem_a", 32'(mem_a), 32'(d));
        chk("burst_pulse_end", 32'(burst_done), 0);
        chk("count_hold", 32'(count), 32'(exp_count));
        ok = (lat <= TO);
        n  = ok ? lat : TO;
        for (int i = 1; i <= n; i++) begin
            mem_done = (i == lat);
            mem_q    = (i == lat) ? q : DW'($urandom);
            step();
            if (i < n) begin
                chk("enable_hold", 32'(mem_enable), 1);
                chk("mem_a_hold", 32'(mem_a), 32'(d));
                chk("ov_wait", 32'(out_valid), 0);
            end
        end
        mem_done = 1'b0;
        if (!ok) begin
            chk("err_set", 32'(error), 1);
            chk("err_en", 32'(mem_enable), 0);
            chk("err_rdy", 32'(in_ready), 0);
            chk("err_ov", 32'(out_valid), 0);
            return;
        end
        chk("resp_valid", 32'(out_valid), 1);
        chk("resp_data", 32'(out_data), 32'(q));
        chk("resp_en", 32'(mem_enable), 0);
        chk("resp_err", 32'(error), 0);
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            mem_done  = 1'($urandom_range(0, 1));
            mem_q     = DW'($urandom);
            step();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'(q));
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_count", 32'(count), 32'(exp_count));
        end
        mem_done  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % BL;
        if (exp_count == 0) bursts++;
        chk("hs_valid", 32'(out_valid), 0);
        chk("hs_count", 32'(count), 32'(exp_count));
        chk("hs_burst", 32'(burst_done), 32'(exp_count == 0));
        chk("hs_ready", 32'(in_ready), 1);
    endtask

    task automatic check_reset_values();
        chk("rst_en", 32'(mem_enable), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_mem_a", 32'(mem_a), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_burst", 32'(burst_done), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_rdy", 32'(in_ready), 0);
    endtask

    initial begin
        int b0;
        // power-on reset
        #1;
        check_reset_values();
        #11 reset = 1'b1;
        chk("rdy_before_edge", 32'(in_ready), 0);
        step();
        chk("rdy_after_edge", 32'(in_ready), 1);

        // single transaction
        txn(16'hA5A5, 3, 16'h1234, 0);
        chk("single_count", 32'(count), 1);

        // finish the burst back-to-back
        b0 = bursts;
        for (int i = 0; i < BL - 1; i++)
            txn(DW'($urandom), $urandom_range(1, TO), DW'($urandom), 0);
        chk("burst_seen", 32'(bursts - b0), 1);
        chk("burst_wrap", 32'(count), 0);

        // mem_done in IDLE is ignored
        mem_done = 1'b1;
        step();
        step();
        mem_done = 1'b0;
        chk("idle_done_en", 32'(mem_enable), 0);
        chk("idle_done_ov", 32'(out_valid), 0);
        chk("idle_done_cnt", 32'(count), 32'(exp_count));

        // backpressure
        txn(16'h0F0F, 2, 16'hBEEF, 5);

        // done on the limit cycle wins
        txn(16'h5555, TO, 16'hCAFE, 1);
        chk("simul_err", 32'(error), 0);

        // random traffic
        for (int i = 0; i < 20; i++)
            txn(DW'($urandom), $urandom_range(1, TO), DW'($urandom),
                $urandom_range(0, 3));

        // reset mid-REQ
        in_data  = 16'h7777;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("midreq_en", 32'(mem_enable), 1);
        step();
        #2 reset = 1'b0;
        #1;
        check_reset_values();
        exp_count = 0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreq_rdy_pre", 32'(in_ready), 0);
        step();
        chk("midreq_rdy", 32'(in_ready), 1);

        // timeout and sticky error
        txn(16'h9999, TO + 1, 16'h0000, 0);
        in_valid = 1'b1;
        mem_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("err_sticky", 32'(error), 1);
            chk("err_rdy_hold", 32'(in_ready), 0);
            chk("err_en_hold", 32'(mem_enable), 0);
            chk("err_ov_hold", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        mem_done = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("err_cleared_rdy", 32'(in_ready), 1);

        // normal operation after recovery
        txn(16'h1111, 1, 16'h2222, 0);
        chk("recover_count", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
